// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: FSM states, opcode classes
// and load funct3 encodings.
package wb_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

  // Opcode class = {op[6], op[4], op[2]}
  localparam logic [2:0] CLS_LOAD  = 3'b000;
  localparam logic [2:0] CLS_ARITH = 3'b010;
  localparam logic [2:0] CLS_UPPER = 3'b011;  // LUI (op[5]=1) / AUIPC (op[5]=0)
  localparam logic [2:0] CLS_JUMP  = 3'b101;  // JAL / JALR

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  function automatic logic [2:0] op_class(input logic [6:0] op);
    return {op[6], op[4], op[2]};
  endfunction

endpackage

// File: rtl/wb_pipe_load_ext.sv
// Load lane selection and sign/zero extension. Purely combinational; also
// flags unsupported funct3 codes and misaligned offsets.
module load_ext
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [2:0]      addr_lo_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o,
  output logic            illegal_o
);

  logic [2:0]      off;
  logic [XLEN-1:0] lane;

  // Shift the addressed lane down to bit 0, then extend by access size.
  always_comb begin
    off       = (XLEN == 64) ? addr_lo_i : {1'b0, addr_lo_i[1:0]};
    lane      = rdata_i >> {off, 3'b000};
    data_o    = '0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = XLEN'($signed(lane[7:0]));
      F3_LBU: data_o = XLEN'(lane[7:0]);
      F3_LH: begin
        data_o    = XLEN'($signed(lane[15:0]));
        illegal_o = off[0];
      end
      F3_LHU: begin
        data_o    = XLEN'(lane[15:0]);
        illegal_o = off[0];
      end
      F3_LW: begin
        data_o    = XLEN'($signed(lane[31:0]));
        illegal_o = |off[1:0];
      end
      F3_LWU: begin
        data_o    = XLEN'(lane[31:0]);
        illegal_o = (XLEN != 64) || (|off[1:0]);
      end
      F3_LD: begin
        data_o    = lane;
        illegal_o = (XLEN != 64) || (|off);
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_pipe.sv
// Write-back stage: computes register-file write data for arithmetic,
// upper-immediate and jump instructions in one cycle, and waits for memory
// data (bounded by MEM_TIMEOUT) for loads.
//
// Handshake: an instruction is accepted on a rising edge where
// in_valid && in_ready. in_ready is high only in IDLE, so while a load waits
// for memory the upstream must hold its instruction. Outputs are registered.
module wb_pipe
  import wb_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_op,
  input  logic [2:0]      in_funct3,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_alu,
  input  logic [19:0]     in_imm_u,
  input  logic [2:0]      in_addr_lo,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            err,
  output logic            dbg_state
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  wb_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic [2:0]      lo_q, lo_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            err_q, err_d;

  logic            accept;
  logic [2:0]      cls;
  logic [XLEN-1:0] imm_u_x;
  logic            nl_we;
  logic [XLEN-1:0] nl_data;
  logic [XLEN-1:0] ext_data;
  logic            ext_illegal;

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3_i  (f3_q),
    .addr_lo_i (lo_q),
    .rdata_i   (mem_rdata),
    .data_o    (ext_data),
    .illegal_o (ext_illegal)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state_q;
  assign rf_we     = rf_we_q;
  assign rf_rd     = rf_rd_q;
  assign rf_wdata  = rf_wdata_q;
  assign err       = err_q;

  // Decode non-load instructions into a write enable and write data.
  always_comb begin
    cls     = op_class(in_op);
    imm_u_x = XLEN'($signed({in_imm_u, 12'b0}));
    nl_we   = 1'b0;
    nl_data = '0;
    case (cls)
      CLS_ARITH: begin
        nl_we   = 1'b1;
        nl_data = in_alu;
      end
      CLS_UPPER: begin
        nl_we   = 1'b1;
        nl_data = in_op[5] ? imm_u_x : (in_pc + imm_u_x);
      end
      CLS_JUMP: begin
        nl_we   = 1'b1;
        nl_data = in_pc + XLEN'(4);
      end
      default: ;
    endcase
  end

  // Next-state logic: accept in IDLE, complete or time out in WAIT_MEM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    f3_d       = f3_q;
    ld_rd_d    = ld_rd_q;
    lo_d       = lo_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cls == CLS_LOAD) begin
            f3_d    = in_funct3;
            ld_rd_d = in_rd;
            lo_d    = in_addr_lo;
            cnt_d   = '0;
            state_d = ST_WAIT_MEM;
          end else if (nl_we && (in_rd != 5'd0)) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = in_rd;
            rf_wdata_d = nl_data;
          end
        end
      end
      ST_WAIT_MEM: begin
        // Data arriving on the timeout cycle still completes the load.
        if (mem_rvalid) begin
          state_d = ST_IDLE;
          if (ext_illegal) begin
            err_d = 1'b1;
          end else if (ld_rd_q != 5'd0) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = ld_rd_q;
            rf_wdata_d = ext_data;
          end
        end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      f3_q       <= '0;
      ld_rd_q    <= '0;
      lo_q       <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      f3_q       <= f3_d;
      ld_rd_q    <= ld_rd_d;
      lo_q       <= lo_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_pipe.sv
// Directed bench for wb_pipe: a 32-bit and a 64-bit instance run the same
// stimulus; each step checks hand-computed results.
module tb_wb_pipe;

  localparam int TMO = 16;

  localparam logic [6:0] OP_ADD   = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LD = 3'b011;
  localparam logic [2:0] LBU = 3'b100, LHU = 3'b101;

  logic        clk, rst_n, in_valid, mem_rvalid;
  logic [6:0]  in_op;
  logic [2:0]  in_f3, in_lo;
  logic [4:0]  in_rd;
  logic [63:0] in_pc, in_alu, mem_rdata;
  logic [19:0] in_imm_u;

  logic        ready32, we32, err32, st32;
  logic [4:0]  rd32;
  logic [31:0] wd32;
  logic        ready64, we64, err64, st64;
  logic [4:0]  rd64;
  logic [63:0] wd64;

  int checks = 0;
  int failures = 0;

  wb_pipe #(.XLEN(32), .MEM_TIMEOUT(TMO)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready32),
    .in_op(in_op), .in_funct3(in_f3), .in_rd(in_rd), .in_pc(in_pc[31:0]),
    .in_alu(in_alu[31:0]), .in_imm_u(in_imm_u), .in_addr_lo(in_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]), .rf_we(we32),
    .rf_rd(rd32), .rf_wdata(wd32), .err(err32), .dbg_state(st32)
  );

  wb_pipe #(.XLEN(64), .MEM_TIMEOUT(TMO)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready64),
    .in_op(in_op), .in_funct3(in_f3), .in_rd(in_rd), .in_pc(in_pc),
    .in_alu(in_alu), .in_imm_u(in_imm_u), .in_addr_lo(in_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rf_we(we64),
    .rf_rd(rd64), .rf_wdata(wd64), .err(err64), .dbg_state(st64)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction for a single accepting edge.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [63:0] pc, input logic [63:0] alu,
                       input logic [19:0] immu, input logic [2:0] lo);
    in_valid = 1'b1;
    in_op    = op;
    in_f3    = f3;
    in_rd    = rd;
    in_pc    = pc;
    in_alu   = alu;
    in_imm_u = immu;
    in_lo    = lo;
    tick();
    in_valid = 1'b0;
  endtask

  // Hold off for n cycles (checking nothing is written), then return data.
  task automatic mem_return(input int n, input logic [63:0] data);
    int wes;
    wes = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (we32 || we64) wes++;
    end
    chk("wait_no_write", 64'(wes), 64'd0);
    chk("wait_not_ready", {62'd0, ready32, ready64}, 64'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    tick();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    int err_at, err_cnt, we_cnt, rdy_at_err, err64_cnt;

    rst_n = 1'b0; in_valid = 1'b0; mem_rvalid = 1'b0; in_op = '0; in_f3 = '0;
    in_rd = '0; in_pc = '0; in_alu = '0; in_imm_u = '0; in_lo = '0; mem_rdata = '0;

    // Reset state
    tick(); tick();
    chk("rst_we", {62'd0, we32, we64}, 64'd0);
    chk("rst_rd", {54'd0, rd32, rd64}, 64'd0);
    chk("rst_wdata32", 64'(wd32), 64'd0);
    chk("rst_wdata64", wd64, 64'd0);
    chk("rst_err", {62'd0, err32, err64}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", {62'd0, ready32, ready64}, 64'd3);
    chk("rst_state", {62'd0, st32, st64}, 64'd0);

    // ADD rd=5 alu=0x1234
    issue(OP_ADD, 3'd0, 5'd5, 64'h0, 64'h1234, 20'h0, 3'd0);
    chk("add_we", {62'd0, we32, we64}, 64'd3);
    chk("add_rd", 64'(rd32), 64'd5);
    chk("add_wdata32", 64'(wd32), 64'h1234);
    chk("add_wdata64", wd64, 64'h1234);
    tick();
    chk("add_we_drop", {62'd0, we32, we64}, 64'd0);
    chk("add_wdata_hold", 64'(wd32), 64'h1234);

    // Back-to-back: ADD then JAL on consecutive edges
    issue(OP_ADD, 3'd0, 5'd6, 64'h0, 64'hFFFF_FFFF_0000_AAAA, 20'h0, 3'd0);
    chk("b2b_add32", 64'(wd32), 64'h0000_AAAA);
    chk("b2b_add64", wd64, 64'hFFFF_FFFF_0000_AAAA);
    issue(OP_JAL, 3'd0, 5'd1, 64'h100, 64'h0, 20'h0, 3'd0);
    chk("jal_we", {62'd0, we32, we64}, 64'd3);
    chk("jal_rd", 64'(rd32), 64'd1);
    chk("jal_wdata", 64'(wd32), 64'h104);

    // AUIPC pc=0x100 imm=1
    issue(OP_AUIPC, 3'd0, 5'd7, 64'h100, 64'h0, 20'h00001, 3'd0);
    chk("auipc_wdata32", 64'(wd32), 64'h1100);
    chk("auipc_wdata64", wd64, 64'h1100);

    // LUI rd=0 -> no write, data held
    issue(OP_LUI, 3'd0, 5'd0, 64'h0, 64'h0, 20'hABCDE, 3'd0);
    chk("lui_rd0_we", {62'd0, we32, we64}, 64'd0);
    chk("lui_rd0_hold", 64'(wd32), 64'h1100);

    // LUI with negative immediate: sign-extended on 64-bit
    issue(OP_LUI, 3'd0, 5'd8, 64'h0, 64'h0, 20'h80000, 3'd0);
    chk("lui_wdata32", 64'(wd32), 64'h8000_0000);
    chk("lui_wdata64", wd64, 64'hFFFF_FFFF_8000_0000);

    // Branch class: no write
    issue(OP_BR, 3'd0, 5'd9, 64'h0, 64'h55, 20'h0, 3'd0);
    chk("branch_we", {62'd0, we32, we64}, 64'd0);

    // LB addr_lo=2 after 3 wait cycles
    issue(OP_LOAD, LB, 5'd10, 64'h0, 64'h0, 20'h0, 3'd2);
    chk("lb_state", {62'd0, st32, st64}, 64'd3);
    mem_return(3, 64'h0000_0000_0080_0000);
    chk("lb_we", {62'd0, we32, we64}, 64'd3);
    chk("lb_rd", 64'(rd32), 64'd10);
    chk("lb_wdata32", 64'(wd32), 64'hFFFF_FF80);
    chk("lb_wdata64", wd64, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_ready", {62'd0, ready32, ready64}, 64'd3);

    // LBU same data
    issue(OP_LOAD, LBU, 5'd10, 64'h0, 64'h0, 20'h0, 3'd2);
    mem_return(3, 64'h0000_0000_0080_0000);
    chk("lbu_wdata32", 64'(wd32), 64'h80);
    chk("lbu_wdata64", wd64, 64'h80);

    // LH / LHU at offset 2
    issue(OP_LOAD, LH, 5'd12, 64'h0, 64'h0, 20'h0, 3'd2);
    mem_return(1, 64'h0000_0000_8001_0000);
    chk("lh_wdata32", 64'(wd32), 64'hFFFF_8001);
    chk("lh_wdata64", wd64, 64'hFFFF_FFFF_FFFF_8001);
    issue(OP_LOAD, LHU, 5'd12, 64'h0, 64'h0, 20'h0, 3'd2);
    mem_return(0, 64'h0000_0000_8001_0000);
    chk("lhu_wdata32", 64'(wd32), 64'h8001);

    // Timeout: no mem_rvalid
    issue(OP_LOAD, LW, 5'd11, 64'h0, 64'h0, 20'h0, 3'd0);
    err_at = 0; err_cnt = 0; we_cnt = 0; rdy_at_err = 0; err64_cnt = 0;
    for (int k = 1; k <= TMO + 4; k++) begin
      tick();
      if (we32 || we64) we_cnt++;
      if (err64) err64_cnt++;
      if (err32) begin
        err_cnt++;
        if (err_at == 0) begin
          err_at = k;
          rdy_at_err = int'(ready32);
        end
      end
    end
    chk("tmo_err_cycle", 64'(err_at), 64'(TMO));
    chk("tmo_err_pulses", 64'(err_cnt), 64'd1);
    chk("tmo_err64_pulses", 64'(err64_cnt), 64'd1);
    chk("tmo_no_write", 64'(we_cnt), 64'd0);
    chk("tmo_ready", 64'(rdy_at_err), 64'd1);

    // mem_rvalid on the timeout cycle wins
    issue(OP_LOAD, LW, 5'd13, 64'h0, 64'h0, 20'h0, 3'd0);
    mem_return(TMO - 1, 64'h0000_0000_1234_5678);
    chk("prio_we", {62'd0, we32, we64}, 64'd3);
    chk("prio_err", {62'd0, err32, err64}, 64'd0);
    chk("prio_wdata32", 64'(wd32), 64'h1234_5678);

    // mem_rvalid ignored in IDLE
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hDEAD;
    tick();
    mem_rvalid = 1'b0;
    chk("idle_rvalid_we", {62'd0, we32, we64}, 64'd0);
    chk("idle_rvalid_state", {62'd0, st32, st64}, 64'd0);

    // LH at odd offset: illegal on both widths
    issue(OP_LOAD, LH, 5'd14, 64'h0, 64'h0, 20'h0, 3'd1);
    mem_return(2, 64'h0000_0000_0000_FF00);
    chk("lh_odd_err", {62'd0, err32, err64}, 64'd3);
    chk("lh_odd_we", {62'd0, we32, we64}, 64'd0);
    tick();
    chk("lh_odd_err_pulse", {62'd0, err32, err64}, 64'd0);

    // LW addr_lo=4: 64-bit picks upper word; 32-bit sees offset 0
    issue(OP_LOAD, LW, 5'd15, 64'h0, 64'h0, 20'h0, 3'd4);
    mem_return(1, 64'h8000_0000_0000_0000);
    chk("lw64_wdata", wd64, 64'hFFFF_FFFF_8000_0000);
    chk("lw32_wdata", 64'(wd32), 64'h0);
    chk("lw_we", {62'd0, we32, we64}, 64'd3);

    // LD: illegal on 32-bit, full word on 64-bit
    issue(OP_LOAD, LD, 5'd16, 64'h0, 64'h0, 20'h0, 3'd0);
    mem_return(1, 64'hA5A5_0000_1111_2222);
    chk("ld_err", {62'd0, err32, err64}, 64'd2);
    chk("ld_we", {62'd0, we32, we64}, 64'd1);
    chk("ld_wdata64", wd64, 64'hA5A5_0000_1111_2222);

    // Reset during WAIT_MEM, then mem_rvalid: no write
    issue(OP_LOAD, LW, 5'd17, 64'h0, 64'h0, 20'h0, 3'd0);
    tick();
    rst_n = 1'b0;
    #2;
    chk("rst_wait_state", {62'd0, st32, st64}, 64'd0);
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h7777_7777;
    tick();
    mem_rvalid = 1'b0;
    chk("rst_wait_we", {62'd0, we32, we64}, 64'd0);
    chk("rst_wait_idle", {62'd0, st32, st64}, 64'd0);
    chk("rst_wait_wdata", 64'(wd32), 64'd0);
    chk("rst_wait_ready", {62'd0, ready32, ready64}, 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
